dl_mem_arbiter: RTL and testbench

DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

---
 rtl/dl_arb_pkg.sv | 20 ++
 rtl/dl_mem_arbiter_if.sv | 25 ++
 rtl/dl_fifo.sv | 58 +++++
 rtl/dl_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dl_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dl_arb_pkg.sv
// Shared types and default sizing for the download/CPU memory arbiter.
package dl_arb_pkg;

   localparam int DEF_ADDR_W     = 25;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_DL_BURST   = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      DL_ACC  = 2'd2
   } arb_state_t;

   // Default-width buffer entry; the arbiter builds its own for non-default ADDR_W.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [7:0]            data;
   } dl_entry_t;

endpackage

// File: rtl/dl_mem_arbiter_if.sv
// Memory command/response bus between the arbiter (master) and the memory (slave).
interface dl_mem_arbiter_if
   import dl_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_din,
      input  mem_dout, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_din,
      output mem_dout, mem_ack
   );

endinterface

// File: rtl/dl_fifo.sv
// Synchronous download write buffer; DEPTH must be a power of two so pointers wrap freely.
module dl_fifo
   import dl_arb_pkg::*;
#(
   parameter int  DEPTH   = DEF_FIFO_DEPTH,
   parameter type entry_t = dl_entry_t
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  entry_t                 wr_entry,
   output entry_t                 head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t           store_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full buffer is accepted when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) store_q[wr_ptr_q] <= wr_entry;
   end

   assign head  = store_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/dl_mem_arbiter.sv
// Arbitrates one memory port between buffered download writes and CPU accesses.
// Define DL_ARB_CPU_HOLD_EN to lock the CPU out for the whole download instead of DL_BURST sharing.
module dl_mem_arbiter
   import dl_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DL_BURST   = DEF_DL_BURST
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dn_go,
   input  logic              dn_wr,
   input  logic [ADDR_W-1:0] dn_addr,
   input  logic [7:0]        dn_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_ack,
   output logic              cpu_wait,
   dl_mem_arbiter_if.master  mem,
   output logic              dl_busy,
   output logic              dl_ovf
);

   localparam int CNT_W = (DL_BURST < 2) ? 1 : $clog2(DL_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DL_BURST);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } entry_w_t;

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  dl_cnt_q, dl_cnt_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_din_q, mem_din_d;
   logic              dl_ovf_q, dl_ovf_d;
   logic              dn_go_prev_q, dn_go_prev_d;

   entry_w_t                    push_entry, head_entry;
   logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        cpu_pend, dl_grant_ok, cpu_grant_ok;

   assign push_entry = {dn_addr, dn_data};

   dl_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_w_t)
   ) u_fifo (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .wr_entry (push_entry),
      .head     (head_entry),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // cpu_req stays high during the ack cycle, so it must not look like a fresh request.
   assign cpu_pend = cpu_req && !cpu_ack_q;

`ifdef DL_ARB_CPU_HOLD_EN
   assign dl_grant_ok  = 1'b1;
   assign cpu_grant_ok = !dn_go;
`else
   assign dl_grant_ok  = !cpu_pend || (dl_cnt_q < BURST_MAX);
   assign cpu_grant_ok = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      dl_cnt_d     = dl_cnt_q;
      cpu_ack_d    = 1'b0;
      cpu_dout_d   = cpu_dout_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      dn_go_prev_d = dn_go;
      fifo_pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!cpu_req) dl_cnt_d = '0;
            if (!fifo_empty && dl_grant_ok) begin
               state_d    = DL_ACC;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b1;
               mem_addr_d = head_entry.addr;
               mem_din_d  = head_entry.data;
            end else if (cpu_pend && cpu_grant_ok) begin
               state_d    = CPU_ACC;
               mem_req_d  = 1'b1;
               mem_we_d   = cpu_we;
               mem_addr_d = cpu_addr;
               mem_din_d  = cpu_din;
            end
         end
         DL_ACC: begin
            if (mem.mem_ack) begin
               fifo_pop   = 1'b1;
               if (dl_cnt_q < BURST_MAX) dl_cnt_d = dl_cnt_q + CNT_W'(1);
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = '0;
               mem_din_d  = '0;
            end
         end
         CPU_ACC: begin
            if (mem.mem_ack) begin
               if (!mem_we_q) cpu_dout_d = mem.mem_dout;
               cpu_ack_d  = 1'b1;
               dl_cnt_d   = '0;
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = '0;
               mem_din_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A dropped byte outranks the clear from a new download starting in the same cycle.
      fifo_push = dn_wr && (!fifo_full || fifo_pop);
      if (dn_wr && fifo_full && !fifo_pop) dl_ovf_d = 1'b1;
      else if (dn_go && !dn_go_prev_q)     dl_ovf_d = 1'b0;
      else                                 dl_ovf_d = dl_ovf_q;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         dl_cnt_q     <= '0;
         cpu_ack_q    <= 1'b0;
         cpu_dout_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         dl_ovf_q     <= 1'b0;
         dn_go_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dl_cnt_q     <= dl_cnt_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_dout_q   <= cpu_dout_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         dl_ovf_q     <= dl_ovf_d;
         dn_go_prev_q <= dn_go_prev_d;
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_we   = mem_we_q;
   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_din  = mem_din_q;
   assign cpu_dout     = cpu_dout_q;
   assign cpu_ack      = cpu_ack_q;
   assign cpu_wait     = cpu_req && !cpu_ack_q;
   assign dl_busy      = dn_go || (fifo_count != '0) || (state_q == DL_ACC);
   assign dl_ovf       = dl_ovf_q;

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Directed bench for dl_mem_arbiter: CPU vector table plus download, overflow, fairness and reset sequences.
module tb_dl_mem_arbiter;
   import dl_arb_pkg::*;

   localparam int ADDR_W = 25;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
      logic [7:0]        rd;
      int                lat;
      logic [7:0]        exp_dout;
   } cpu_vec_t;

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic              dn_go, dn_wr;
   logic [ADDR_W-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_din;
   logic [7:0]        cpu_dout;
   logic              cpu_ack, cpu_wait, dl_busy, dl_ovf;

   always #5 clk_sys = ~clk_sys;

   dl_mem_arbiter_if #(.ADDR_W(ADDR_W)) mif ();

   dl_mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (4),
      .DL_BURST   (2)
   ) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .dn_go    (dn_go),
      .dn_wr    (dn_wr),
      .dn_addr  (dn_addr),
      .dn_data  (dn_data),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_dout (cpu_dout),
      .cpu_ack  (cpu_ack),
      .cpu_wait (cpu_wait),
      .mem      (mif),
      .dl_busy  (dl_busy),
      .dl_ovf   (dl_ovf)
   );

   // Memory model: acks mem_lat edges after it first sees mem_req, logs every write.
   int                mem_lat   = 1;
   logic              mem_hold  = 1'b0;
   logic              stray_ack = 1'b0;
   logic [7:0]        rd_value  = 8'h00;
   int                lat_cnt   = 0;
   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [7:0]        wr_data_q [$];

   always @(posedge clk_sys) begin
      mif.mem_ack <= 1'b0;
      if (stray_ack) begin
         mif.mem_ack  <= 1'b1;
         mif.mem_dout <= 8'hC3;
      end else if (mif.mem_req && !mif.mem_ack && !mem_hold) begin
         if (lat_cnt + 1 >= mem_lat) begin
            mif.mem_ack  <= 1'b1;
            mif.mem_dout <= mif.mem_we ? 8'hEE : rd_value;
            lat_cnt      <= 0;
            if (mif.mem_we) begin
               wr_addr_q.push_back(mif.mem_addr);
               wr_data_q.push_back(mif.mem_din);
            end
         end else begin
            lat_cnt <= lat_cnt + 1;
         end
      end else if (!mif.mem_req) begin
         lat_cnt <= 0;
      end
   end

   // Event monitor: ack pulses, request starts, the last command and writes done before each CPU read grant.
   int                ack_cnt      = 0;
   int                req_rise     = 0;
   int                cpu_grant_wr = 0;
   logic              req_prev     = 1'b0;
   logic              cmd_we       = 1'b0;
   logic [ADDR_W-1:0] cmd_addr     = '0;
   logic [7:0]        cmd_din      = '0;

   always @(posedge clk_sys) begin
      if (cpu_ack) ack_cnt <= ack_cnt + 1;
      if (mif.mem_req && !req_prev) begin
         req_rise <= req_rise + 1;
         cmd_we   <= mif.mem_we;
         cmd_addr <= mif.mem_addr;
         cmd_din  <= mif.mem_din;
         if (!mif.mem_we) cpu_grant_wr <= wr_addr_q.size();
      end
      req_prev <= mif.mem_req;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic push_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      dn_wr   = 1'b1;
      dn_addr = a;
      dn_data = d;
      @(negedge clk_sys);
      dn_wr   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 300 && (dl_busy || mif.mem_req); i++) @(negedge clk_sys);
      check_output({name, " drain"}, {30'd0, dl_busy, mif.mem_req}, 32'd0);
   endtask

   task automatic wait_cpu_ack(input string name);
      int  i;
      logic seen;
      seen = 1'b0;
      for (i = 0; i < 80; i++) begin
         if (cpu_ack) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk_sys);
      end
      check_output({name, " ack seen"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic apply_stimulus(input cpu_vec_t v, input int idx);
      int a0, r0, w0;
      a0       = ack_cnt;
      r0       = req_rise;
      w0       = wr_addr_q.size();
      mem_lat  = v.lat;
      rd_value = v.rd;
      cpu_we   = v.we;
      cpu_addr = v.addr;
      cpu_din  = v.din;
      cpu_req  = 1'b1;
      @(negedge clk_sys);
      check_output($sformatf("vec%0d wait", idx), {31'd0, cpu_wait}, 32'd1);
      wait_cpu_ack($sformatf("vec%0d", idx));
      check_output($sformatf("vec%0d dout", idx), {24'd0, cpu_dout}, {24'd0, v.exp_dout});
      check_output($sformatf("vec%0d wait@ack", idx), {31'd0, cpu_wait}, 32'd0);
      cpu_req = 1'b0;
      tick(3);
      check_output($sformatf("vec%0d ack pulses", idx), ack_cnt - a0, 32'd1);
      check_output($sformatf("vec%0d mem_req count", idx), req_rise - r0, 32'd1);
      check_output($sformatf("vec%0d cmd we", idx), {31'd0, cmd_we}, {31'd0, v.we});
      check_output($sformatf("vec%0d cmd addr", idx), {7'd0, cmd_addr}, {7'd0, v.addr});
      if (v.we) check_output($sformatf("vec%0d cmd din", idx), {24'd0, cmd_din}, {24'd0, v.din});
      check_output($sformatf("vec%0d writes", idx), wr_addr_q.size() - w0, {31'd0, v.we});
      check_output($sformatf("vec%0d dout hold", idx), {24'd0, cpu_dout}, {24'd0, v.exp_dout});
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      cpu_vec_t vecs [5];
      int w0, a0;
      int exp_grant_wr;

      vecs[0] = '{we: 1'b0, addr: 25'h0000100, din: 8'h00, rd: 8'hA5, lat: 2, exp_dout: 8'hA5};
      vecs[1] = '{we: 1'b1, addr: 25'h0000200, din: 8'h3C, rd: 8'h11, lat: 1, exp_dout: 8'hA5};
      vecs[2] = '{we: 1'b0, addr: 25'h1FFFFFF, din: 8'h00, rd: 8'h5A, lat: 4, exp_dout: 8'h5A};
      vecs[3] = '{we: 1'b1, addr: 25'h0000000, din: 8'hFF, rd: 8'h22, lat: 3, exp_dout: 8'h5A};
      vecs[4] = '{we: 1'b0, addr: 25'h0000000, din: 8'h00, rd: 8'h00, lat: 1, exp_dout: 8'h00};

      reset_n  = 1'b1;
      dn_go    = 1'b0;
      dn_wr    = 1'b0;
      dn_addr  = '0;
      dn_data  = '0;
      cpu_req  = 1'b0;
      cpu_we   = 1'b0;
      cpu_addr = '0;
      cpu_din  = '0;
      #1 reset_n = 1'b0;
      tick(3);
      check_output("reset mem_req", {31'd0, mif.mem_req}, 32'd0);
      check_output("reset cpu_ack", {31'd0, cpu_ack}, 32'd0);
      check_output("reset dl_busy", {31'd0, dl_busy}, 32'd0);
      reset_n = 1'b1;
      tick(2);
      check_output("reset cpu_dout", {24'd0, cpu_dout}, 32'd0);
      check_output("reset dl_ovf", {31'd0, dl_ovf}, 32'd0);
      check_output("reset cpu_wait", {31'd0, cpu_wait}, 32'd0);

      for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

      $display("[TB] download 16 bytes, one per 4 cycles");
      mem_lat = 1;
      w0      = wr_addr_q.size();
      dn_go   = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push_byte(25'h1000 + 25'(i), 8'h30 + 8'(i));
         tick(3);
      end
      dn_go = 1'b0;
      wait_idle("dl16");
      check_output("dl16 writes", wr_addr_q.size() - w0, 32'd16);
      if (wr_addr_q.size() >= w0 + 16) begin
         for (int i = 0; i < 16; i++) begin
            check_output($sformatf("dl16 addr%0d", i), {7'd0, wr_addr_q[w0+i]}, 32'h1000 + 32'(i));
            check_output($sformatf("dl16 data%0d", i), {24'd0, wr_data_q[w0+i]}, 32'h30 + 32'(i));
         end
      end
      check_output("dl16 ovf", {31'd0, dl_ovf}, 32'd0);

      $display("[TB] overflow with 6-cycle memory");
      mem_lat = 6;
      w0      = wr_addr_q.size();
      dn_go   = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         dn_wr   = 1'b1;
         dn_addr = 25'h2000 + 25'(k);
         dn_data = 8'h50 + 8'(k);
         @(negedge clk_sys);
         if (k == 4) check_output("ovf after 4", {31'd0, dl_ovf}, 32'd0);
         if (k == 5) check_output("ovf after 5", {31'd0, dl_ovf}, 32'd1);
      end
      dn_wr = 1'b0;
      dn_go = 1'b0;
      @(negedge clk_sys);
      check_output("busy after go fall", {31'd0, dl_busy}, 32'd1);
      check_output("ovf sticky", {31'd0, dl_ovf}, 32'd1);
      wait_idle("ovf");
      check_output("ovf writes", wr_addr_q.size() - w0, 32'd4);
      if (wr_addr_q.size() >= w0 + 4) begin
         check_output("ovf first addr", {7'd0, wr_addr_q[w0]}, 32'h2001);
         check_output("ovf last data", {24'd0, wr_data_q[w0+3]}, 32'h54);
      end
      dn_go = 1'b1;
      @(negedge clk_sys);
      check_output("ovf clear on go", {31'd0, dl_ovf}, 32'd0);
      dn_go = 1'b0;
      tick(1);

      $display("[TB] push and pop on full buffer");
      mem_lat  = 1;
      mem_hold = 1'b1;
      w0       = wr_addr_q.size();
      dn_go    = 1'b1;
      for (int k = 1; k <= 4; k++) push_byte(25'h3000 + 25'(k), 8'h60 + 8'(k));
      tick(2);
      mem_hold = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (mif.mem_ack) begin
               seen = 1'b1;
               break;
            end
         end
         check_output("full pushpop ack seen", {31'd0, seen}, 32'd1);
      end
      push_byte(25'h3005, 8'h65);
      check_output("full pushpop ovf", {31'd0, dl_ovf}, 32'd0);
      dn_go = 1'b0;
      wait_idle("pushpop");
      check_output("pushpop writes", wr_addr_q.size() - w0, 32'd5);
      if (wr_addr_q.size() >= w0 + 5) begin
         check_output("pushpop 5th addr", {7'd0, wr_addr_q[w0+4]}, 32'h3005);
         check_output("pushpop 5th data", {24'd0, wr_data_q[w0+4]}, 32'h65);
      end

      $display("[TB] overflow set and go-rise clear in the same cycle");
      mem_hold = 1'b1;
      w0       = wr_addr_q.size();
      dn_go    = 1'b1;
      for (int k = 1; k <= 4; k++) push_byte(25'h4000 + 25'(k), 8'h70 + 8'(k));
      dn_go = 1'b0;
      @(negedge clk_sys);
      dn_go = 1'b1;
      push_byte(25'h40FF, 8'hFF);
      check_output("ovf push wins", {31'd0, dl_ovf}, 32'd1);
      dn_go    = 1'b0;
      mem_hold = 1'b0;
      wait_idle("pushwins");
      check_output("pushwins writes", wr_addr_q.size() - w0, 32'd4);
      dn_go = 1'b1;
      @(negedge clk_sys);
      check_output("pushwins clear", {31'd0, dl_ovf}, 32'd0);
      dn_go = 1'b0;
      tick(1);

      $display("[TB] full buffer with CPU pending");
`ifdef DL_ARB_CPU_HOLD_EN
      exp_grant_wr = 4;
`else
      exp_grant_wr = 2;
`endif
      mem_hold = 1'b1;
      mem_lat  = 1;
      dn_go    = 1'b1;
      for (int k = 1; k <= 4; k++) push_byte(25'h5000 + 25'(k), 8'h80 + 8'(k));
      dn_go = 1'b0;
      tick(1);
      w0       = wr_addr_q.size();
      rd_value = 8'h77;
      cpu_we   = 1'b0;
      cpu_addr = 25'h0ABC;
      cpu_req  = 1'b1;
      @(negedge clk_sys);
      mem_hold = 1'b0;
      wait_cpu_ack("fair");
      cpu_req = 1'b0;
      check_output("fair dout", {24'd0, cpu_dout}, 32'h77);
      check_output("fair writes before cpu", cpu_grant_wr - w0, exp_grant_wr);
      wait_idle("fair");
      check_output("fair total writes", wr_addr_q.size() - w0, 32'd4);

      $display("[TB] reset during download access");
      mem_hold = 1'b1;
      w0       = wr_addr_q.size();
      a0       = ack_cnt;
      dn_go    = 1'b1;
      for (int k = 1; k <= 3; k++) push_byte(25'h6000 + 25'(k), 8'h90 + 8'(k));
      tick(2);
      check_output("rst pre mem_req", {31'd0, mif.mem_req}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_output("rst mem_req", {31'd0, mif.mem_req}, 32'd0);
      check_output("rst mem_we", {31'd0, mif.mem_we}, 32'd0);
      check_output("rst mem_addr", {7'd0, mif.mem_addr}, 32'd0);
      check_output("rst mem_din", {24'd0, mif.mem_din}, 32'd0);
      check_output("rst busy follows go", {31'd0, dl_busy}, 32'd1);
      dn_go = 1'b0;
      #1;
      check_output("rst fifo empty", {31'd0, dl_busy}, 32'd0);
      @(negedge clk_sys);
      reset_n  = 1'b1;
      mem_hold = 1'b0;
      @(negedge clk_sys);
      stray_ack = 1'b1;
      @(negedge clk_sys);
      stray_ack = 1'b0;
      tick(3);
      check_output("stray mem_req", {31'd0, mif.mem_req}, 32'd0);
      check_output("stray writes", wr_addr_q.size() - w0, 32'd0);
      check_output("stray cpu_ack", ack_cnt - a0, 32'd0);
      check_output("stray busy", {31'd0, dl_busy}, 32'd0);
      check_output("stray cpu_dout", {24'd0, cpu_dout}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
